handshake_fwd_slice: RTL and testbench
======================================

// Module: handshake_fwd_slice
// PURPOSE
//   Full register slice for the valid/ready stream handshake: a 2-entry buffer (output reg + skid reg).
//   Opposite direction to our ready-path skid stage: valid_post_o, data_post_o and ready_pre_o all come
//   straight from flops, so both the forward and the backward timing paths are cut.
//   Full throughput of 1 beat/cycle; sits between pipeline stages on long or congested routes.
// PARAMETERS
//   DATA_W   8   payload width in bits
// PORTS
//   clk           input   1       clock, all logic on posedge
//   rst_n         input   1       asynchronous active-low reset
//   flush_i       input   1       synchronous flush: discard all buffered beats
//   valid_pre_i   input   1       upstream beat valid
//   data_pre_i    input   DATA_W  upstream payload
//   ready_pre_o   output  1       to upstream: slice can accept; registered
//   valid_post_o  output  1       to downstream: output reg holds a beat; registered
//   data_post_o   output  DATA_W  downstream payload; registered
//   ready_post_i  input   1       downstream can accept
//   count_o       output  2       beats held (0..2); registered
// BEHAVIOUR
//   - Reset (async assert, sync release): state EMPTY, valid_post_o=0, ready_pre_o=1,
//     data_post_o=0, skid data=0, count_o=0.
//   - in_fire = valid_pre_i & ready_pre_o; out_fire = valid_post_o & ready_post_i.
//   - FSM, one-hot or 2-bit encoding, outputs decoded from registers only:
//       EMPTY (cnt 0): valid_post_o=0, ready_pre_o=1
//       BUSY  (cnt 1): valid_post_o=1, ready_pre_o=1
//       FULL  (cnt 2): valid_post_o=1, ready_pre_o=0
//   - Transitions (flush_i=0):
//       EMPTY: in_fire -> BUSY, out_reg<=data_pre_i; else stay.
//       BUSY : in_fire & out_fire -> BUSY, out_reg<=data_pre_i.
//              in_fire & !out_fire -> FULL, skid<=data_pre_i.
//              !in_fire & out_fire -> EMPTY.  neither -> stay.
//       FULL : out_fire -> BUSY, out_reg<=skid.  else stay (no in_fire possible).
//   - Latency: beat accepted in cycle N appears on valid_post_o/data_post_o in cycle N+1.
//   - Order is strict FIFO; no beat is dropped or duplicated except by flush.
//   - Throughput 1 beat/cycle in steady state when ready_post_i stays high.
//   - ready_post_i may toggle freely; ready_pre_o drops one cycle after the slice fills,
//     and the skid reg absorbs the beat accepted in that cycle.
//   - data_post_o stable while valid_post_o=1 and ready_post_i=0 (AXI-style hold).
//   - Upstream may drop valid_pre_i without a handshake; the slice makes no assumption about it.
//   - Flush: flush_i=1 has top priority. Next state EMPTY, count_o=0, ready_pre_o=1.
//     An in_fire in the same cycle is discarded. An out_fire in the same cycle counts as delivered.
//     Data regs are not cleared.
//   - Async reset mid-transfer: all buffered beats lost; outputs take reset values immediately.
//   - Invariants: count_o==0 <-> !valid_post_o; count_o==2 <-> !ready_pre_o; count_o never 3.
// TESTING
//   1. Reset: rst_n=0 at arbitrary times -> valid_post_o=0, ready_pre_o=1, count_o=0, data_post_o=0 at once.
//   2. Streaming: ready_post_i=1, send 0x01..0x10 back-to-back -> same sequence out, 1 cycle later,
//      no bubbles, count_o=1 throughout.
//   3. Backpressure: hold ready_post_i=0, send 0xA1,0xA2,0xA3 -> 0xA1,0xA2 accepted, ready_pre_o=0,
//      count_o=2, 0xA3 held upstream. Release -> 0xA1,0xA2,0xA3 delivered in order.
//   4. Random valid/ready: random valid_pre_i and ready_post_i at 50%, 10k beats -> scoreboard matches exactly.
//      data_post_o stable while stalled; invariants hold every cycle.
//   5. Flush while FULL, with valid_pre_i=1 and ready_post_i=1 in the same cycle -> head beat delivered,
//      input beat dropped, next cycle count_o=0, ready_pre_o=1.
//   6. Drain: fill to FULL, then ready_post_i=1 with valid_pre_i=0 -> count_o 2->1->0 over two cycles,
//      valid_post_o low after the second.

Source files
------------

// File: rtl/handshake_fwd_slice_if.sv
// Valid/ready stream bundle for the forward register slice.
// Upstream (pre) and downstream (post) sides share one interface.
//   valid_pre_i/data_pre_i/ready_pre_o    : upstream side
//   valid_post_o/data_post_o/ready_post_i : downstream side
interface handshake_fwd_slice_if #(
  parameter int DATA_W = 8
);
  logic              valid_pre_i;
  logic [DATA_W-1:0] data_pre_i;
  logic              ready_pre_o;
  logic              valid_post_o;
  logic [DATA_W-1:0] data_post_o;
  logic              ready_post_i;

  // slice side
  modport slave (
    input  valid_pre_i,
    input  data_pre_i,
    output ready_pre_o,
    output valid_post_o,
    output data_post_o,
    input  ready_post_i
  );

  // environment side: drives upstream beats and downstream ready
  modport master (
    output valid_pre_i,
    output data_pre_i,
    input  ready_pre_o,
    input  valid_post_o,
    input  data_post_o,
    output ready_post_i
  );
endinterface

// File: rtl/handshake_fwd_slice.sv
// Full register slice: 2-entry buffer (output reg + skid reg).
// Ports: clk, rst_n (async low), flush_i, s_if (slave), count_o.
module handshake_fwd_slice #(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  handshake_fwd_slice_if.slave s_if,
  output logic [1:0]           count_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_valid;
  logic              r_ready;
  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_skid;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_ld_out_in;
  logic              w_ld_out_skid;
  logic              w_ld_skid;
  logic              w_valid_nxt;
  logic              w_ready_nxt;
  logic [1:0]        w_count_nxt;

  assign w_in_fire  = s_if.valid_pre_i & r_ready;
  assign w_out_fire = r_valid & s_if.ready_post_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_ld_out_in   = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    if (flush_i) begin
      // buffered beats dropped; data regs keep stale contents
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_BUSY;
            w_ld_out_in = 1'b1;
          end
        end
        S_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_out_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = S_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // ready_pre_o is low here, so no in_fire
          if (w_out_fire) begin
            w_state_nxt   = S_BUSY;
            w_ld_out_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // Outputs come from dedicated flops loaded
  // with the decode of the next state.
  always_comb begin
    w_valid_nxt = 1'b0;
    w_ready_nxt = 1'b1;
    w_count_nxt = 2'd0;
    unique case (w_state_nxt)
      S_EMPTY: begin
        w_valid_nxt = 1'b0;
        w_ready_nxt = 1'b1;
        w_count_nxt = 2'd0;
      end
      S_BUSY: begin
        w_valid_nxt = 1'b1;
        w_ready_nxt = 1'b1;
        w_count_nxt = 2'd1;
      end
      S_FULL: begin
        w_valid_nxt = 1'b1;
        w_ready_nxt = 1'b0;
        w_count_nxt = 2'd2;
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_ready_nxt = 1'b1;
        w_count_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_count <= 2'd0;
    end else begin
      r_valid <= w_valid_nxt;
      r_ready <= w_ready_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_ld_out_in) begin
      r_data <= s_if.data_pre_i;
    end else if (w_ld_out_skid) begin
      r_data <= r_skid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else if (w_ld_skid) begin
      r_skid <= s_if.data_pre_i;
    end
  end

  assign s_if.valid_post_o = r_valid;
  assign s_if.ready_pre_o  = r_ready;
  assign s_if.data_post_o  = r_data;
  assign count_o           = r_count;

endmodule

// File: tb/tb_handshake_fwd_slice.sv
// Self-checking bench for handshake_fwd_slice.
// Directed vectors plus a queue reference model.
module tb_handshake_fwd_slice;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] cnt;

  handshake_fwd_slice_if #(.DATA_W(DW)) bus ();

  handshake_fwd_slice #(.DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .s_if    (bus.slave),
    .count_o (cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // One cycle: drive, check at negedge, update model at posedge.
  task automatic step(input logic v, input logic [7:0] d,
                      input logic r, input logic f);
    logic       mv;
    logic       mr;
    logic [7:0] hd;
    bus.valid_pre_i  = v;
    bus.data_pre_i   = d;
    bus.ready_post_i = r;
    flush            = f;
    @(negedge clk);
    mv = q.size() > 0;
    mr = q.size() < 2;
    check("valid", 32'(bus.valid_post_o), 32'(mv));
    check("ready", 32'(bus.ready_pre_o), 32'(mr));
    check("count", 32'(cnt), 32'(q.size()));
    if (mv) check("data", 32'(bus.data_post_o), 32'(q[0]));
    @(posedge clk);
    if (mv && r) hd = q.pop_front();
    if (f) q.delete();
    else if (v && mr) q.push_back(d);
    #1;
  endtask

  initial begin
    bus.valid_pre_i  = 1'b0;
    bus.data_pre_i   = '0;
    bus.ready_post_i = 1'b0;
    #12;
    check("rst_valid", 32'(bus.valid_post_o), 32'd0);
    check("rst_ready", 32'(bus.ready_pre_o), 32'd1);
    check("rst_count", 32'(cnt), 32'd0);
    check("rst_data", 32'(bus.data_post_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // streaming 0x01..0x10
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    check("stream_cnt", 32'(cnt), 32'd1);
    check("stream_last", 32'(bus.data_post_o), 32'h10);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // backpressure
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    check("bp_cnt", 32'(cnt), 32'd2);
    check("bp_ready", 32'(bus.ready_pre_o), 32'd0);
    check("bp_head", 32'(bus.data_post_o), 32'hA1);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    step(1'b1, 8'hA3, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_empty", 32'(bus.valid_post_o), 32'd0);

    // flush while FULL with in and out fire
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    check("fl_full", 32'(cnt), 32'd2);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    check("fl_cnt", 32'(cnt), 32'd0);
    check("fl_ready", 32'(bus.ready_pre_o), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // drain from FULL
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("dr_cnt1", 32'(cnt), 32'd1);
    check("dr_head", 32'(bus.data_post_o), 32'hC2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("dr_cnt0", 32'(cnt), 32'd0);
    check("dr_valid", 32'(bus.valid_post_o), 32'd0);

    // async reset mid-transfer
    step(1'b1, 8'hD1, 1'b0, 1'b0);
    step(1'b1, 8'hD2, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(bus.valid_post_o), 32'd0);
    check("mr_ready", 32'(bus.ready_pre_o), 32'd1);
    check("mr_count", 32'(cnt), 32'd0);
    check("mr_data", 32'(bus.data_post_o), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // random valid/ready against the queue model
    for (int i = 0; i < 20000; i++) begin
      step(1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("end_cnt", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
